// File: rtl/upe_led_serialiser.sv
// Replays one captured adder result {carry, sum} on a single LED:
// a framing gap, then each of the WIDTH+1 bits held for HOLD_CYCLES clocks.
module upe_led_serialiser #(
  parameter int WIDTH       = 32,
  parameter int HOLD_CYCLES = 1250,
  parameter int GAP_CYCLES  = 5000,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               sum_in,
  input  logic                           carry_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           led_data,
  output logic                           led_frame,
  output logic                           busy,
  output logic [$clog2(WIDTH+1)-1:0]     bit_index
);

  localparam int IW   = $clog2(WIDTH+1);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC+1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES-1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES-1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH);

  typedef enum logic [1:0] {IDLE, GAP, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             led_q, led_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] sum_ord;

  // Shift register always emits from bit 0, so MSB-first order is a capture-time reversal.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
    assign sum_ord[gi] = MSB_FIRST ? sum_in[WIDTH-1-gi] : sum_in[gi];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    led_d   = led_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = {carry_in, sum_ord};
          cnt_d   = '0;
          idx_d   = '0;
          led_d   = 1'b0;
          frame_d = 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          led_d   = shreg_q[0];
          frame_d = 1'b0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            shreg_d = '0;
            idx_d   = '0;
            led_d   = 1'b0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            // Output is registered, so present the next bit as the shift happens.
            shreg_d = shreg_q >> 1;
            led_d   = shreg_q[1];
            idx_d   = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        frame_d = 1'b0;
        led_d   = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      led_q   <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign led_data  = led_q;
  assign led_frame = frame_q;
  assign busy      = busy_q;
  assign bit_index = idx_q;

endmodule

// File: tb/tb_upe_led_serialiser.sv
// Bench for upe_led_serialiser: three instances (LSB-first 2/3, MSB-first 2/3, LSB-first 1/1)
// share stimulus; a frame-position model is checked every cycle, plus literal expectations.
module tb_upe_led_serialiser;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sum_in;
  logic        carry_in;
  logic        in_valid;
  logic [2:0]  o_ready, o_led, o_frame, o_busy;
  logic [5:0]  o_idx [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  upe_led_serialiser #(.WIDTH(32), .HOLD_CYCLES(2), .GAP_CYCLES(3), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .sum_in(sum_in), .carry_in(carry_in), .in_valid(in_valid),
    .in_ready(o_ready[0]), .led_data(o_led[0]), .led_frame(o_frame[0]), .busy(o_busy[0]),
    .bit_index(o_idx[0]));
  upe_led_serialiser #(.WIDTH(32), .HOLD_CYCLES(2), .GAP_CYCLES(3), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .sum_in(sum_in), .carry_in(carry_in), .in_valid(in_valid),
    .in_ready(o_ready[1]), .led_data(o_led[1]), .led_frame(o_frame[1]), .busy(o_busy[1]),
    .bit_index(o_idx[1]));
  upe_led_serialiser #(.WIDTH(32), .HOLD_CYCLES(1), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .reset(reset), .sum_in(sum_in), .carry_in(carry_in), .in_valid(in_valid),
    .in_ready(o_ready[2]), .led_data(o_led[2]), .led_frame(o_frame[2]), .busy(o_busy[2]),
    .bit_index(o_idx[2]));

  function automatic void check(string nm, logic [31:0] act_v, logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
    end
  endfunction

  // Model: each instance is either idle or at a position within a frame of fixed length.
  int   gap_c  [3] = '{3, 3, 1};
  int   hold_c [3] = '{2, 2, 1};
  bit   msb_c  [3] = '{1'b0, 1'b1, 1'b0};
  bit   act    [3] = '{1'b0, 1'b0, 1'b0};
  int   pos    [3] = '{0, 0, 0};
  logic [32:0] cap [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) act[i] = 1'b0;
      else if (act[i]) begin
        pos[i] = pos[i] + 1;
        if (pos[i] == gap_c[i] + 33*hold_c[i]) act[i] = 1'b0;
      end else if (in_valid) begin
        act[i] = 1'b1;
        pos[i] = 0;
        cap[i] = {carry_in, sum_in};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic e_rdy, e_led, e_frm, e_bsy;
        int   e_idx, j;
        e_rdy = 1'b1; e_led = 1'b0; e_frm = 1'b0; e_bsy = 1'b0; e_idx = 0;
        if (act[i]) begin
          e_rdy = 1'b0; e_bsy = 1'b1;
          if (pos[i] < gap_c[i]) e_frm = 1'b1;
          else begin
            j     = (pos[i] - gap_c[i]) / hold_c[i];
            e_idx = j;
            if (j == 32) e_led = cap[i][32];
            else e_led = msb_c[i] ? cap[i][31-j] : cap[i][j];
          end
        end
        check($sformatf("dut%0d in_ready", i), 32'(o_ready[i]), 32'(e_rdy));
        check($sformatf("dut%0d led_data", i), 32'(o_led[i]), 32'(e_led));
        check($sformatf("dut%0d led_frame", i), 32'(o_frame[i]), 32'(e_frm));
        check($sformatf("dut%0d busy", i), 32'(o_busy[i]), 32'(e_bsy));
        check($sformatf("dut%0d bit_index", i), 32'(o_idx[i]), 32'(e_idx));
      end
    end
  end

  logic rec_d0 [100], rec_b0 [100], rec_r0 [100], rec_d1 [100], rec_d2 [100], rec_b2 [100];

  task automatic accept(input logic [31:0] s, input logic c);
    @(negedge clk);
    sum_in = s; carry_in = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Position m is the m-th negedge after the acceptance edge (m=0 is the first).
  task automatic record(input int chg_at, input logic [31:0] chg_val);
    for (int m = 0; m < 100; m++) begin
      if (m > 0) @(negedge clk);
      if (m == chg_at) sum_in = chg_val;
      rec_d0[m] = o_led[0]; rec_b0[m] = o_busy[0]; rec_r0[m] = o_ready[0];
      rec_d1[m] = o_led[1]; rec_d2[m] = o_led[2]; rec_b2[m] = o_busy[2];
    end
  endtask

  int exp2 [8] = '{1, 0, 0, 0, 1, 1, 0, 0};
  int exp3 [8] = '{0, 0, 1, 1, 0, 1, 0, 0};
  int exp6 [6] = '{0, 1, 1, 0, 1, 0};

  initial begin
    int n0, n2;
    reset = 1'b1; in_valid = 1'b0; sum_in = '0; carry_in = 1'b0;
    repeat (4) @(negedge clk);
    chk_en = 1'b1;
    check("rst ready", 32'(o_ready), 32'h7);
    check("rst busy", 32'(o_busy), 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle led", 32'(o_led | o_frame), 32'h0);
    $display("txn reset/idle done");

    accept(32'h34D51531, 1'b1);
    record(-1, 32'h0);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("lsb bit%0d", j), 32'(rec_d0[3+2*j]), 32'(exp2[j]));
      check($sformatf("msb bit%0d", j), 32'(rec_d1[3+2*j]), 32'(exp3[j]));
    end
    check("lsb carry", 32'(rec_d0[67]), 32'h1);
    check("msb carry", 32'(rec_d1[67]), 32'h1);
    n0 = 0;
    for (int m = 0; m < 100; m++) n0 += int'(rec_b0[m]);
    check("busy len 2/3", 32'(n0), 32'd69);
    $display("txn frame 34D51531/1 LSB and MSB done");

    @(negedge clk);
    sum_in = 32'hFFFFFFFF; carry_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    record(10, 32'h0);
    in_valid = 1'b0;
    check("held bit10", 32'(rec_d0[23]), 32'h1);
    check("held bit31", 32'(rec_d0[65]), 32'h1);
    check("held carry", 32'(rec_d0[67]), 32'h0);
    check("end busy", 32'(rec_b0[68]), 32'h1);
    check("gap idle", 32'(rec_b0[69]), 32'h0);
    check("gap ready", 32'(rec_r0[69]), 32'h1);
    check("second start", 32'(rec_b0[70]), 32'h1);
    check("second bit0", 32'(rec_d0[73]), 32'h0);
    $display("txn back-to-back FFFFFFFF then 0 done");
    repeat (120) @(negedge clk);

    accept(32'hFFFF0000, 1'b1);
    repeat (23) @(negedge clk);
    check("pre-abort idx", 32'(o_idx[0]), 32'd10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort ready", 32'(o_ready), 32'h7);
    check("abort outs", 32'(o_busy | o_led | o_frame), 32'h0);
    check("abort idx", 32'(o_idx[0]), 32'h0);
    accept(32'h34D51531, 1'b1);
    record(-1, 32'h0);
    check("restart bit0", 32'(rec_d0[3]), 32'h1);
    check("restart bit1", 32'(rec_d0[5]), 32'h0);
    check("restart bit4", 32'(rec_d0[11]), 32'h1);
    $display("txn mid-frame reset and restart done");

    accept(32'h55555556, 1'b1);
    record(-1, 32'h0);
    check("fast gap led", 32'(rec_d2[0]), 32'h0);
    for (int j = 0; j < 6; j++)
      check($sformatf("fast bit%0d", j), 32'(rec_d2[1+j]), 32'(exp6[j]));
    n2 = 0;
    for (int m = 0; m < 100; m++) n2 += int'(rec_b2[m]);
    check("busy len 1/1", 32'(n2), 32'd34);
    $display("txn frame 55555556/1 fast timing done");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
